// File: rtl/ula_sched.sv
// rtl/ula_sched.sv - round-robin scheduler sharing one ULA datapath between two requesters
// Define ULA_SCHED_ACC_EN to add the accumulator operand source (req_use_acc).
module ula_sched #(
  parameter int W       = 6,
  parameter int ALU_LAT = 2
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W+3:0] req0_cmd,
  input  logic [2*W+3:0] req1_cmd,
`ifdef ULA_SCHED_ACC_EN
  input  logic [1:0]     req_use_acc,
`endif
  output logic [W-1:0]   alu_A,
  output logic [W-1:0]   alu_B,
  output logic [2:0]     alu_operacao,
  output logic           alu_modo,
  output logic           alu_start,
  input  logic [W-1:0]   alu_resultado,
  input  logic           alu_overflow,
  input  logic           alu_zero,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_resultado,
  output logic           rsp_overflow,
  output logic           rsp_zero
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam logic [3:0] LAT   = 4'(ALU_LAT);

  logic [1:0]     state;
  logic           last_grant;
  logic [3:0]     cnt;
  logic [2*W+3:0] cmd_q;
  logic           grant0;
  logic           grant1;
  logic           accept;
  logic           capture;

  // last_grant=1 means req1 was served last, so req0 takes the next tie
  always_comb begin
    grant0    = req_valid[0] & (~req_valid[1] | last_grant);
    grant1    = req_valid[1] & (~req_valid[0] | ~last_grant);
    req_ready = 2'b00;
    if (reset && state == IDLE) req_ready = {grant1, grant0};
  end

  assign accept       = |req_ready;
  assign capture      = (state == WAIT) && (cnt == 4'd1);
  assign alu_B        = cmd_q[2*W-1:W];
  assign alu_operacao = cmd_q[2*W+2:2*W];
  assign alu_modo     = cmd_q[2*W+3];
  assign alu_start    = (state == ISSUE);
  assign rsp_valid    = (state == RESP);

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      cnt           <= 4'd0;
      cmd_q         <= '0;
      rsp_id        <= 1'b0;
      rsp_resultado <= '0;
      rsp_overflow  <= 1'b0;
      rsp_zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_q      <= req_ready[1] ? req1_cmd : req0_cmd;
            rsp_id     <= req_ready[1];
            last_grant <= req_ready[1];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= LAT;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (capture) begin
            rsp_resultado <= alu_resultado;
            rsp_overflow  <= alu_overflow;
            rsp_zero      <= alu_zero;
            state         <= RESP;
          end
        end
        default: begin
          if (rsp_ready) state <= IDLE;
        end
      endcase
    end
  end

`ifdef ULA_SCHED_ACC_EN
  logic [W-1:0] acc;
  logic         use_q;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      acc   <= '0;
      use_q <= 1'b0;
    end else begin
      if (accept) use_q <= req_ready[1] ? req_use_acc[1] : req_use_acc[0];
      if (capture) acc <= alu_resultado;
    end
  end

  assign alu_A = use_q ? acc : cmd_q[W-1:0];
`else
  assign alu_A = cmd_q[W-1:0];
`endif

endmodule

// File: tb/tb_ula_sched.sv
// tb/tb_ula_sched.sv - scoreboard bench for ula_sched with a fixed-latency ULA model
// Accumulator checks run when ULA_SCHED_ACC_EN is defined.
module tb_ula_sched;
  localparam int W   = 6;
  localparam int LAT = 2;

  logic           CLOCK_50 = 1'b0;
  logic           reset;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [1:0]     req_use_acc;
  logic [2*W+3:0] req0_cmd;
  logic [2*W+3:0] req1_cmd;
  logic [W-1:0]   alu_A;
  logic [W-1:0]   alu_B;
  logic [2:0]     alu_operacao;
  logic           alu_modo;
  logic           alu_start;
  logic [W-1:0]   alu_resultado;
  logic           alu_overflow;
  logic           alu_zero;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [W-1:0]   rsp_resultado;
  logic           rsp_overflow;
  logic           rsp_zero;

  always #5 CLOCK_50 = ~CLOCK_50;

  ula_sched #(.W(W), .ALU_LAT(LAT)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
`ifdef ULA_SCHED_ACC_EN
    .req_use_acc(req_use_acc),
`endif
    .alu_A(alu_A), .alu_B(alu_B), .alu_operacao(alu_operacao), .alu_modo(alu_modo),
    .alu_start(alu_start), .alu_resultado(alu_resultado), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_resultado(rsp_resultado), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero)
  );

  // returns {overflow, zero, result}
  function automatic logic [W+1:0] ula(input logic modo, input logic [2:0] op,
                                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         v;
    r = a;
    v = 1'b0;
    if (!modo) begin
      if (op == 3'd0) begin
        r = a + b;
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end else if (op == 3'd1) begin
        r = a - b;
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
    end else begin
      case (op)
        3'd0:    r = a & b;
        3'd1:    r = a | b;
        3'd2:    r = a ^ b;
        default: r = ~a;
      endcase
    end
    return {v, r == '0, r};
  endfunction

  // ULA outputs are only correct in the cycle ALU_LAT after alu_start; garbage otherwise
  int           lat_cnt = 0;
  logic [W+1:0] ula_now;
  always @(posedge CLOCK_50) begin
    if (!reset) lat_cnt <= 0;
    else if (alu_start) lat_cnt <= 1;
    else if (lat_cnt != 0 && lat_cnt < 100) lat_cnt <= lat_cnt + 1;
  end
  always_comb begin
    ula_now = ula(alu_modo, alu_operacao, alu_A, alu_B);
    if (lat_cnt != LAT) ula_now = ~ula_now;
  end
  assign {alu_overflow, alu_zero, alu_resultado} = ula_now;

  logic [W+2:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_rsp    = 0;
  int           cyc      = 0;
  int           hs_cyc   = 0;
  int           acc_cyc  = 0;
  logic         last_m   = 1'b1;
  logic [W-1:0] acc_m    = '0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    logic [W+2:0] e;
    #1;
    if (reset && rsp_valid && rsp_ready) begin
      n_rsp++;
      hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_val("rsp_unexpected", 32'(rsp_valid), 32'(1'b0));
      end else begin
        e = exp_q.pop_front();
        check_val("rsp_id", 32'(rsp_id), 32'(e[W+2]));
        check_val("rsp_resultado", 32'(rsp_resultado), 32'(e[W-1:0]));
        check_val("rsp_overflow", 32'(rsp_overflow), 32'(e[W+1]));
        check_val("rsp_zero", 32'(rsp_zero), 32'(e[W]));
      end
    end
  end

  task automatic do_accept(input logic [1:0] v, input logic [1:0] ua);
    logic [1:0]     pred;
    logic           win;
    logic [2*W+3:0] c;
    logic [W-1:0]   a;
    logic [W+1:0]   r;
    req_valid   = v;
    req_use_acc = ua;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (req_ready != 2'b00) break;
      @(negedge CLOCK_50);
    end
    win  = (v == 2'b11) ? ~last_m : v[1];
    pred = win ? 2'b10 : 2'b01;
    check_val("req_ready_grant", 32'(req_ready), 32'(pred));
    acc_cyc = cyc;
    c = win ? req1_cmd : req0_cmd;
    a = ua[win] ? acc_m : c[W-1:0];
    r = ula(c[2*W+3], c[2*W+2:2*W], a, c[2*W-1:W]);
    acc_m  = r[W-1:0];
    last_m = win;
    exp_q.push_back({win, r});
    @(negedge CLOCK_50);
  endtask

  task automatic wait_rsp();
    int n0;
    n0 = n_rsp;
    for (int i = 0; i < 40 && n_rsp == n0; i++) @(negedge CLOCK_50);
    check_val("rsp_seen", 32'(n_rsp), 32'(n0 + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W+2:0] e;
    int           n0;
    reset       = 1'b0;
    req_valid   = 2'b11;
    req_use_acc = 2'b00;
    rsp_ready   = 1'b0;
    req0_cmd    = {1'b0, 3'd0, 6'd3, 6'd5};
    req1_cmd    = {1'b1, 3'd0, 6'h15, 6'h2A};
    repeat (2) @(negedge CLOCK_50);
    check_val("rst_req_ready", 32'(req_ready), 32'(2'b00));
    check_val("rst_alu_A", 32'(alu_A), 32'(0));
    check_val("rst_alu_B", 32'(alu_B), 32'(0));
    check_val("rst_alu_op", 32'(alu_operacao), 32'(0));
    check_val("rst_alu_modo", 32'(alu_modo), 32'(0));
    check_val("rst_alu_start", 32'(alu_start), 32'(0));
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check_val("rst_rsp_id", 32'(rsp_id), 32'(0));
    check_val("rst_rsp_res", 32'(rsp_resultado), 32'(0));
    check_val("rst_rsp_ovf", 32'(rsp_overflow), 32'(0));
    check_val("rst_rsp_zero", 32'(rsp_zero), 32'(0));
    reset     = 1'b1;
    rsp_ready = 1'b1;

    // first tie after reset goes to req0; 5+3 with exact issue/response timing
    do_accept(2'b11, 2'b00);
    req_valid = 2'b00;
    check_val("t1_start_issue", 32'(alu_start), 32'(1));
    check_val("t1_alu_A", 32'(alu_A), 32'(5));
    check_val("t1_alu_B", 32'(alu_B), 32'(3));
    @(negedge CLOCK_50);
    check_val("t1_start_wait", 32'(alu_start), 32'(0));
    check_val("t1_alu_A_hold", 32'(alu_A), 32'(5));
    @(negedge CLOCK_50);
    check_val("t1_rsp_early", 32'(rsp_valid), 32'(0));
    @(negedge CLOCK_50);
    check_val("t1_rsp_valid", 32'(rsp_valid), 32'(1));
    wait_rsp();

    // req1 alone, signed overflow 31+1
    req1_cmd = {1'b0, 3'd0, 6'd1, 6'd31};
    do_accept(2'b10, 2'b00);
    req_valid = 2'b00;
    wait_rsp();

    // both held: alternation 0,1,0,1
    req0_cmd = {1'b0, 3'd1, 6'd9, 6'd7};
    req1_cmd = {1'b1, 3'd0, 6'h15, 6'h2A};
    for (int k = 0; k < 4; k++) begin
      do_accept(2'b11, 2'b00);
      wait_rsp();
    end

    // consumer stalls for 5 cycles, then 1-cycle turnaround to next grant
    rsp_ready = 1'b0;
    req0_cmd  = {1'b1, 3'd2, 6'h0F, 6'h33};
    do_accept(2'b11, 2'b00);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge CLOCK_50);
    e = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      #2;
      check_val("stall_rsp_valid", 32'(rsp_valid), 32'(1));
      check_val("stall_rsp_id", 32'(rsp_id), 32'(e[W+2]));
      check_val("stall_rsp_res", 32'(rsp_resultado), 32'(e[W-1:0]));
      check_val("stall_req_ready", 32'(req_ready), 32'(2'b00));
      @(negedge CLOCK_50);
    end
    rsp_ready = 1'b1;
    wait_rsp();
    do_accept(2'b11, 2'b00);
    check_val("turnaround", 32'(acc_cyc - hs_cyc), 32'(1));
    req_valid = 2'b00;
    wait_rsp();

    // reset during WAIT abandons the req0 op; last_grant back to 1
    req0_cmd = {1'b0, 3'd0, 6'd2, 6'd4};
    do_accept(2'b01, 2'b00);
    req_valid = 2'b00;
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b1;
    exp_q.delete();
    last_m = 1'b1;
    acc_m  = '0;
    n0 = n_rsp;
    for (int i = 0; i < 6; i++) begin
      check_val("abort_rsp_valid", 32'(rsp_valid), 32'(0));
      @(negedge CLOCK_50);
    end
    check_val("abort_no_rsp", 32'(n_rsp), 32'(n0));
    req0_cmd = {1'b0, 3'd0, 6'd1, 6'd1};
    do_accept(2'b11, 2'b00);
    req_valid = 2'b00;
    wait_rsp();

`ifdef ULA_SCHED_ACC_EN
    req0_cmd = {1'b0, 3'd0, 6'd1, 6'd10};
    do_accept(2'b01, 2'b00);
    req_valid = 2'b00;
    wait_rsp();
    req0_cmd = {1'b0, 3'd0, 6'd2, 6'd0};
    do_accept(2'b01, 2'b01);
    check_val("acc_alu_A", 32'(alu_A), 32'(11));
    req_valid = 2'b00;
    wait_rsp();
`endif

    repeat (3) @(negedge CLOCK_50);
    check_val("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
